// File: rtl/puf_harvester.sv
// Purpose: steps a challenge source, fires NCH arbiter PUFs, packs response bits into WORD_W-bit words for a capture RAM.
// Latency: one evaluation = 2*SETTLE+4 cycles; one word = (WORD_W/NCH)*(2*SETTLE+4)+1 cycles (majority-vote build: 2+SETTLE+VOTES*(SETTLE+2) per evaluation).
// Backpressure: none; the capture RAM must accept every mem_wr strobe, and the block stops by itself once the last address is written.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, sel          run request (level, sampled in IDLE) and challenge select (1 = chal_cst)
//   chal_cst, chal_lfsr constant challenge / LFSR stage output
//   lfsr_en             one-cycle LFSR step strobe
//   challenge           registered challenge to the PUF array, frozen while an evaluation is in flight
//   puf_en              one-cycle PUF launch pulse
//   response            PUF outputs, bit i = channel i
//   mem_addr/data/wr    capture RAM write port (mem_addr idles at all ones so the first write lands on 0)
//   busy, done          busy in every state except IDLE; done from the last-address write until restart
//
// Optional feature: define PUF_HARV_VOTE_EN to evaluate each challenge VOTES times and store the
// per-channel majority. Without it each sample is stored directly and no vote counters exist.

module puf_harvester #(
  parameter int CHAL_W = 128,
  parameter int NCH    = 1,
  parameter int WORD_W = 128,
  parameter int ADDR_W = 13,
  parameter int SETTLE = 32,
  parameter int VOTES  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sel,
  input  logic [CHAL_W-1:0] chal_cst,
  input  logic [CHAL_W-1:0] chal_lfsr,
  output logic              lfsr_en,
  output logic [CHAL_W-1:0] challenge,
  output logic              puf_en,
  input  logic [NCH-1:0]    response,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              busy,
  output logic              done
);

  localparam int BITS = WORD_W / NCH;                     // evaluations per word
  localparam int BC_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int WC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BITS - 1);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  if ((WORD_W % NCH) != 0 || SETTLE < 1 || (VOTES % 2) == 0) begin : g_bad_params
    $error("puf_harvester: WORD_W must be a multiple of NCH, SETTLE >= 1 and VOTES odd");
  end

  typedef enum logic [2:0] {
    IDLE,
    LFSR_STEP,
    LFSR_WAIT,
    PUF_FIRE,
    PUF_WAIT,
    SAMPLE,
    WORD_CHK,
    MEM_WRITE
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic [WORD_W-1:0] word;
  logic              stop;
  logic              sel_q;

  // Bits shifted into the word after an evaluation, and whether this SAMPLE
  // closes the evaluation of the current challenge.
  logic [NCH-1:0]    sample_bits;
  logic              last_vote;
  logic [WORD_W-1:0] word_shift;

  // Keeps the low WORD_W bits of {word, sample_bits}; also correct when NCH == WORD_W.
  assign word_shift = WORD_W'({word, sample_bits});

  // Challenge must not move between launch and capture of the PUF race.
  logic hold_chal;
  assign hold_chal = (state == PUF_FIRE) || (state == PUF_WAIT) || (state == SAMPLE);

`ifdef PUF_HARV_VOTE_EN
  localparam int OC_W = $clog2(VOTES + 1);
  localparam int VC_W = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(VOTES - 1);

  logic [OC_W-1:0] ones     [NCH];
  logic [OC_W-1:0] ones_inc [NCH];
  logic [VC_W-1:0] vote_cnt;

  // Majority includes the sample being taken right now.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ones_inc[i]    = ones[i] + OC_W'(response[i]);
      sample_bits[i] = (ones_inc[i] > OC_W'(VOTES / 2));
    end
  end

  assign last_vote = (vote_cnt == VC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || state == LFSR_STEP) begin
      vote_cnt <= '0;
      for (int i = 0; i < NCH; i++) ones[i] <= '0;
    end else if (state == SAMPLE) begin
      vote_cnt <= vote_cnt + 1'b1;
      for (int i = 0; i < NCH; i++) ones[i] <= ones_inc[i];
    end
  end
`else
  assign last_vote   = 1'b1;
  assign sample_bits = response;
`endif

  // Single FSM; strobes are registered, so they are raised on the edge that
  // enters the state they belong to and dropped by the default below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      word      <= '0;
      stop      <= 1'b0;
      sel_q     <= 1'b0;
      lfsr_en   <= 1'b0;
      puf_en    <= 1'b0;
      mem_wr    <= 1'b0;
      challenge <= '0;
      mem_addr  <= ADDR_LAST;
      mem_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      lfsr_en <= 1'b0;
      puf_en  <= 1'b0;
      mem_wr  <= 1'b0;

      if (!hold_chal) begin
        challenge <= sel_q ? chal_cst : chal_lfsr;
      end

      case (state)
        IDLE: begin
          if (!start) begin
            // A restart needs start to drop at least once after completion.
            stop <= 1'b0;
            done <= 1'b0;
          end else if (!stop) begin
            bit_cnt <= BC_LAST;
            sel_q   <= sel;
            busy    <= 1'b1;
            lfsr_en <= 1'b1;
            state   <= LFSR_STEP;
          end
        end

        LFSR_STEP: begin
          wait_cnt <= WC_LAST;
          state    <= LFSR_WAIT;
        end

        LFSR_WAIT: begin
          if (wait_cnt == '0) begin
            puf_en <= 1'b1;
            state  <= PUF_FIRE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        PUF_FIRE: begin
          wait_cnt <= WC_LAST;
          state    <= PUF_WAIT;
        end

        PUF_WAIT: begin
          if (wait_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        SAMPLE: begin
          if (last_vote) begin
            word  <= word_shift;
            state <= WORD_CHK;
          end else begin
            // Re-fire the same challenge; no LFSR step between votes.
            puf_en <= 1'b1;
            state  <= PUF_FIRE;
          end
        end

        WORD_CHK: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
            lfsr_en <= 1'b1;
            state   <= LFSR_STEP;
          end else begin
            mem_data <= word;
            mem_addr <= mem_addr + 1'b1;
            mem_wr   <= 1'b1;
            state    <= MEM_WRITE;
          end
        end

        MEM_WRITE: begin
          if (mem_addr == ADDR_LAST) begin
            stop  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            bit_cnt <= BC_LAST;
            lfsr_en <= 1'b1;
            state   <= LFSR_STEP;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_harvester.sv
// Purpose: self-checking bench for puf_harvester (NCH=1 and NCH=2 instances, WORD_W=8, ADDR_W=2, SETTLE=2).
// Latency: a full capture of four words takes about 4*(8*EVAL+1) cycles per table entry.
// Backpressure: none; every write strobe is checked against the scoreboard as it appears.

module tb_puf_harvester;

  localparam int S = 2;
`ifdef PUF_HARV_VOTE_EN
  localparam int NV = 3;
  localparam logic [7:0] E2 = 8'hFF;
  localparam logic [7:0] E3 = 8'h00;
`else
  localparam int NV = 1;
  localparam logic [7:0] E2 = 8'hB6;
  localparam logic [7:0] E3 = 8'h24;
`endif
  localparam int EVAL  = 2 + S + NV * (S + 2);
  localparam int WPER1 = 8 * EVAL + 1;
  localparam int WPER2 = 4 * EVAL + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, sel;
  logic [15:0] chal_cst, chal_lfsr;

  logic        lfsr_en, puf_en, mem_wr, busy, done;
  logic [15:0] challenge;
  logic [0:0]  response;
  logic [1:0]  mem_addr;
  logic [7:0]  mem_data;

  logic        lfsr_en2, puf_en2, mem_wr2, busy2, done2;
  logic [15:0] challenge2;
  logic [1:0]  response2;
  logic [1:0]  mem_addr2;
  logic [7:0]  mem_data2;

  puf_harvester #(.CHAL_W(16), .NCH(1), .WORD_W(8), .ADDR_W(2), .SETTLE(S), .VOTES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .chal_cst(chal_cst), .chal_lfsr(chal_lfsr),
    .lfsr_en(lfsr_en), .challenge(challenge), .puf_en(puf_en), .response(response),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .busy(busy), .done(done)
  );

  puf_harvester #(.CHAL_W(16), .NCH(2), .WORD_W(8), .ADDR_W(2), .SETTLE(S), .VOTES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .chal_cst(chal_cst), .chal_lfsr(chal_lfsr),
    .lfsr_en(lfsr_en2), .challenge(challenge2), .puf_en(puf_en2), .response(response2),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_wr(mem_wr2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic        sel;
    logic [15:0] cst;
    logic [15:0] lf;
    logic [7:0]  pat;   // response sequence, bit k%plen for sample k
    int          plen;
    logic [7:0]  exp;   // expected first stored word
  } vec_t;

  vec_t vecs [5];

  int total = 0;
  int bad   = 0;

  // stimulus / model state, owned by the single initial process
  int          cyc = 0;
  logic [7:0]  pat_cur;
  int          plen_cur;
  int          samp_idx;
  logic [15:0] exp_chal;
  logic [7:0]  acc;
  int          nbits;
  logic [1:0]  sb_addr;
  logic [9:0]  sb_q [$];
`ifdef PUF_HARV_VOTE_EN
  int          vseen;
  int          vones;
`endif
  int          lf_in_word, last_lf, lf_run;
  int          wr_run, last_wr;
  bit          prev_wr_ok, last_wr_top;
  logic [7:0]  first_data;
  logic [1:0]  first_addr;
  int          p2, last_wr2;
  bit          prev2_ok;
  logic [1:0]  a2_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bit(input logic b);
    acc = {acc[6:0], b};
    nbits++;
    if (nbits == 8) begin
      sb_q.push_back({sb_addr, acc});
      sb_addr = sb_addr + 2'd1;
      nbits   = 0;
    end
  endtask

  // Advance one cycle and observe both DUTs at the falling edge.
  task automatic step();
    logic       b;
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      nbits = 0; acc = '0; sb_q.delete(); sb_addr = 2'd0;
`ifdef PUF_HARV_VOTE_EN
      vseen = 0; vones = 0;
`endif
      lf_in_word = 0; prev_wr_ok = 1'b0; last_wr_top = 1'b0;
      p2 = 0; prev2_ok = 1'b0; a2_addr = 2'd0;
    end else begin
      if (last_wr_top) check("done_after_last_write", 64'(done), 64'd1);
      last_wr_top = 1'b0;

      if (lfsr_en) begin
        if (lf_in_word > 0) check("lfsr_spacing", 64'(cyc - last_lf), 64'(EVAL));
        last_lf = cyc;
        lf_in_word++;
        lf_run++;
      end

      if (puf_en) begin
        check("challenge_at_fire", 64'(challenge), 64'(exp_chal));
        b = pat_cur[samp_idx % plen_cur];
        samp_idx++;
        response = b;
`ifdef PUF_HARV_VOTE_EN
        vones += int'(b);
        vseen++;
        if (vseen == NV) begin
          push_bit(vones > NV / 2);
          vseen = 0;
          vones = 0;
        end
`else
        push_bit(b);
`endif
      end

      if (mem_wr) begin
        wr_run++;
        if (wr_run == 1) begin
          first_data = mem_data;
          first_addr = mem_addr;
        end
        check("lfsr_per_word", 64'(lf_in_word), 64'd8);
        lf_in_word = 0;
        if (prev_wr_ok) check("word_period", 64'(cyc - last_wr), 64'(WPER1));
        prev_wr_ok  = (mem_addr != 2'b11);
        last_wr_top = (mem_addr == 2'b11);
        last_wr     = cyc;
        if (sb_q.size() == 0) begin
          check("scoreboard_has_entry", 64'd0, 64'd1);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e[9:8]));
          check("wr_data", 64'(mem_data), 64'(e[7:0]));
        end
      end

      if (puf_en2) p2++;
      if (mem_wr2) begin
        check("nch2_data", 64'(mem_data2), 64'hAA);
        check("nch2_addr", 64'(mem_addr2), 64'(a2_addr));
        check("nch2_fires_per_word", 64'(p2), 64'(4 * NV));
        if (prev2_ok) check("nch2_word_period", 64'(cyc - last_wr2), 64'(WPER2));
        prev2_ok = (mem_addr2 != 2'b11);
        last_wr2 = cyc;
        a2_addr  = a2_addr + 2'd1;
        p2       = 0;
      end
    end
  endtask

  initial begin
    int wr_hold;

    vecs[0] = '{sel: 1'b1, cst: 16'd5,     lf: 16'h0000, pat: 8'h01, plen: 1, exp: 8'hFF};
    vecs[1] = '{sel: 1'b1, cst: 16'd5,     lf: 16'h0000, pat: 8'h01, plen: 2, exp: 8'hAA};
    vecs[2] = '{sel: 1'b1, cst: 16'h1234,  lf: 16'h0F0F, pat: 8'h05, plen: 3, exp: E2};
    vecs[3] = '{sel: 1'b1, cst: 16'h00F0,  lf: 16'h0F0F, pat: 8'h04, plen: 3, exp: E3};
    vecs[4] = '{sel: 1'b0, cst: 16'd5,     lf: 16'hBEEF, pat: 8'h03, plen: 4, exp: 8'hCC};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0;
    chal_cst = '0; chal_lfsr = '0;
    response = 1'b0; response2 = 2'b10;
    pat_cur = 8'h01; plen_cur = 1; samp_idx = 0; exp_chal = '0;
    lf_run = 0; wr_run = 0; last_lf = 0; last_wr = 0; last_wr2 = 0;
    first_data = '0; first_addr = '0;

    repeat (2) step();
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_done",      64'(done),       64'd0);
    check("rst_mem_wr",    64'(mem_wr),     64'd0);
    check("rst_lfsr_en",   64'(lfsr_en),    64'd0);
    check("rst_puf_en",    64'(puf_en),     64'd0);
    check("rst_mem_addr",  64'(mem_addr),   64'd3);
    check("rst_mem_data",  64'(mem_data),   64'd0);
    check("rst_challenge", 64'(challenge),  64'd0);
    check("rst2_mem_addr", 64'(mem_addr2),  64'd3);
    check("rst2_busy",     64'(busy2),      64'd0);
    check("rst2_lfsr_en",  64'(lfsr_en2),   64'd0);
    check("rst2_chal",     64'(challenge2), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      sel       = vecs[v].sel;
      chal_cst  = vecs[v].cst;
      chal_lfsr = vecs[v].lf;
      pat_cur   = vecs[v].pat;
      plen_cur  = vecs[v].plen;
      exp_chal  = vecs[v].sel ? vecs[v].cst : vecs[v].lf;
      samp_idx  = 0;
      start     = 1'b0;
      step();
      check("done_cleared_by_start_low", 64'(done), 64'd0);
      start  = 1'b1;
      wr_run = 0;
      lf_run = 0;
      for (int c = 0; c < 4 * WPER1 + 50; c++) begin
        step();
        if (done) break;
      end
      check("run_done", 64'(done), 64'd1);
      check("run_writes", 64'(wr_run), 64'd4);
      check("run_lfsr_steps", 64'(lf_run), 64'd32);
      check("run_first_word", 64'(first_data), 64'(vecs[v].exp));
      check("run_first_addr", 64'(first_addr), 64'd0);
      wr_hold = wr_run;
      repeat (20) step();
      check("no_write_after_done", 64'(wr_run), 64'(wr_hold));
      check("idle_busy_after_done", 64'(busy), 64'd0);
      check("done_held", 64'(done), 64'd1);
      check("nch2_done_held", 64'(done2), 64'd1);
    end

    // Abort during PUF_WAIT of the second word, then restart from address 0.
    start = 1'b0;
    step();
    start  = 1'b1;
    wr_run = 0;
    for (int c = 0; c < 2 * WPER1 && wr_run < 1; c++) step();
    check("abort_first_word_written", 64'(wr_run), 64'd1);
    for (int c = 0; c < 2 * EVAL; c++) begin
      step();
      if (puf_en) break;
    end
    check("abort_saw_fire", 64'(puf_en), 64'd1);
    step();
    check("abort_busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd3);
    check("abort_mem_wr",   64'(mem_wr),   64'd0);
    check("abort_done",     64'(done),     64'd0);
    rst_n  = 1'b1;
    wr_run = 0;
    for (int c = 0; c < 2 * WPER1 && wr_run < 1; c++) step();
    check("restart_wrote", 64'(wr_run), 64'd1);
    check("restart_addr", 64'(first_addr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
